dcache_unit: RTL and testbench
==============================

// Module: dcache_unit
// PURPOSE
// - Direct-mapped, write-back, write-allocate data cache with its miss-handling controller, in the MEM stage.
// - Services lw/sw/lb/sb from the ALU address. On a miss, freezes the pipeline (lock=1, pc_enable=0) and sequences the
//   memory transfers: write-back of a dirty victim, then line fill.
// - Returns the hit word plus the byte lane to the writeback stage.
// PARAMETERS
// - INDEX_BITS   13  line index width; 2**INDEX_BITS one-word lines; tag = addr[31:INDEX_BITS+2]
// - MEM_LATENCY  4   cycles one main-memory read or write occupies (>=1)
// PORTS
// - clk          in   1   single clock; all state updates on rising edge
// - rst          in   1   synchronous, active-high reset
// - opcode       in   6   MIPS opcode of the MEM-stage instr; 6'b111111 = bubble/nop (an all-zero instr maps here)
// - addr         in   32  effective byte address (ALU result)
// - rt_data      in   32  store data
// - mem_rdata    in   32  main-memory read word; byte0 = [7:0]
// - mem_addr     out  32  main-memory word address: victim address while writing back, else addr
// - mem_wdata    out  32  victim line data (= cache_rdata)
// - mem_we       out  1   main-memory write enable
// - cache_rdata  out  32  word stored at addr's line (combinational)
// - byte_number  out  2   addr[1:0]
// - is_word      out  1   1 for lw/sw, 0 for lb/sb and all others
// - cache_hit    out  1   valid && tag match (combinational)
// - cache_dirty  out  1   dirty bit of indexed line
// - reg_write    out  1   load result may be written to the register file this cycle
// - pc_enable    out  1   PC / pipeline registers may advance
// - lock         out  1   pipeline stall request (always equals !pc_enable)
// BEHAVIOUR
// - Opcodes: lw 100011, lb 100000, sw 101011, sb 101000; all others are non-memory.
// - Non-memory op: no cache/memory activity; pc_enable=1, lock=0, reg_write=0, mem_we=0.
// - Arrays: per line valid, dirty, tag, 32-bit data; index = addr[INDEX_BITS+1:2].
// - Reset: all valid and dirty bits cleared; FSM=IDLE; counter=0. Outputs after reset: mem_we=0, lock=0, pc_enable=1.
// - FSM states IDLE, WB, FILL.
// - IDLE, memory op, hit:
//   - lw/lb: reg_write=1, pc_enable=1, lock=0.
//   - sw: whole word <= rt_data on the edge. sb: lane byte_number <= rt_data[7:0], other lanes kept.
//   - Any store sets dirty=1; pc_enable=1, lock=0.
// - IDLE, memory op, miss: lock=1, pc_enable=0, reg_write=0 in that same cycle.
//   - Next state WB if the line is valid&&dirty, else FILL. Counter loads 0.
// - WB: mem_we=1; mem_addr = {victim_tag, index, 2'b00}; mem_wdata = victim data.
//   - After MEM_LATENCY cycles: dirty <= 0, go to FILL.
// - FILL: mem_we=0; mem_addr = {addr[31:2], 2'b00}.
//   - On the MEM_LATENCY-th cycle: data <= mem_rdata, tag <= addr tag, valid=1, dirty=0; return to IDLE.
// - After refill, IDLE re-evaluates the still-held instruction as a hit (store merges then) and releases the stall.
// - Miss latency:
//   - clean miss: 1 + MEM_LATENCY stall cycles.
//   - dirty miss: 1 + 2*MEM_LATENCY stall cycles.
// - Inputs opcode/addr/rt_data are held stable by the pipeline while lock=1.
// - Reset mid-WB/FILL: abort transfer, mem_we=0 next cycle, all lines invalid.
// - Index wrap: tag/index fields are taken strictly from addr bits; no other address arithmetic.
// TESTING
// - After rst, lw 0x00000010 (mem_rdata=0xDEADBEEF): lock=1 for 1+MEM_LATENCY cycles, mem_we=0;
//   then cache_hit=1, reg_write=1, cache_rdata=0xDEADBEEF.
// - sw 0x00000010 rt=0x11223344 on hit: no stall; next lw 0x10 reads 0x11223344; cache_dirty=1.
// - sb 0x00000013 rt=0xAB on that line: cache_rdata=0xAB223344; byte_number=3; is_word=0.
// - lw 0x00008010 (same index, INDEX_BITS=13, other tag), victim dirty: mem_we=1 for MEM_LATENCY cycles
//   with mem_addr=0x10 and mem_wdata=0xAB223344; then fill from 0x8010; total stall 1+2*MEM_LATENCY.
// - opcode=111111 and R-type opcode 000000: pc_enable=1, lock=0, mem_we=0, no array change.
// - Assert rst during FILL: FSM idle, lock=0 next cycle, prior hit address now misses.

Source files
------------

// File: rtl/dcache_unit.sv
// Direct-mapped write-back / write-allocate data cache for the MEM stage.
// Misses stall the pipeline while a dirty victim is written back and the line refilled.
module dcache_unit #(
   parameter int INDEX_BITS  = 13,
   parameter int MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [31:0] rt_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic [31:0] cache_rdata,
   output logic [1:0]  byte_number,
   output logic        is_word,
   output logic        cache_hit,
   output logic        cache_dirty,
   output logic        reg_write,
   output logic        pc_enable,
   output logic        lock
);

   localparam int NL = 1 << INDEX_BITS;
   localparam int TW = 30 - INDEX_BITS;
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_LB = 6'b100000;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_SB = 6'b101000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_FILL
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;

   logic [NL-1:0]    r_valid;
   logic [NL-1:0]    r_dirty;
   logic [TW-1:0]    r_tag  [NL];
   logic [31:0]      r_data [NL];

   logic [INDEX_BITS-1:0] w_idx;
   logic [TW-1:0]    w_tag;
   logic [TW-1:0]    w_vtag;
   logic             w_lw;
   logic             w_lb;
   logic             w_sw;
   logic             w_sb;
   logic             w_load;
   logic             w_store;
   logic             w_store_hit;
   logic             w_wb_done;
   logic             w_fill_done;
   logic [31:0]      w_merged;

   assign w_idx  = addr[INDEX_BITS+1:2];
   assign w_tag  = addr[31:INDEX_BITS+2];
   assign w_vtag = r_tag[w_idx];

   assign w_lw    = (opcode == OP_LW);
   assign w_lb    = (opcode == OP_LB);
   assign w_sw    = (opcode == OP_SW);
   assign w_sb    = (opcode == OP_SB);
   assign w_load  = w_lw | w_lb;
   assign w_store = w_sw | w_sb;

   assign cache_rdata = r_data[w_idx];
   assign cache_hit   = r_valid[w_idx] && (w_vtag == w_tag);
   assign cache_dirty = r_dirty[w_idx];
   assign byte_number = addr[1:0];
   assign is_word     = w_lw | w_sw;
   assign mem_wdata   = cache_rdata;
   assign lock        = !pc_enable;

   always_comb begin
      w_merged = cache_rdata;
      if (w_sw) begin
         w_merged = rt_data;
      end else begin
         unique case (byte_number)
            2'd0: w_merged[7:0]   = rt_data[7:0];
            2'd1: w_merged[15:8]  = rt_data[7:0];
            2'd2: w_merged[23:16] = rt_data[7:0];
            2'd3: w_merged[31:24] = rt_data[7:0];
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      mem_we      = 1'b0;
      mem_addr    = {addr[31:2], 2'b00};
      reg_write   = 1'b0;
      pc_enable   = 1'b1;
      w_store_hit = 1'b0;
      w_wb_done   = 1'b0;
      w_fill_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_load || w_store) begin
               if (cache_hit) begin
                  reg_write   = w_load;
                  w_store_hit = w_store;
               end else begin
                  pc_enable = 1'b0;
                  w_cnt_nxt = '0;
                  w_state_nxt = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
               end
            end
         end
         S_WB: begin
            pc_enable = 1'b0;
            mem_we    = 1'b1;
            mem_addr  = {w_vtag, w_idx, 2'b00};
            if (r_cnt == LAST) begin
               w_wb_done   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_FILL;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_FILL: begin
            pc_enable = 1'b0;
            if (r_cnt == LAST) begin
               w_fill_done = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (w_fill_done) begin
         r_valid[w_idx] <= 1'b1;
         r_dirty[w_idx] <= 1'b0;
      end else if (w_wb_done) begin
         r_dirty[w_idx] <= 1'b0;
      end else if (w_store_hit) begin
         r_dirty[w_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset so they can map onto RAM; valid gates them.
   always_ff @(posedge clk) begin
      if (!rst && w_fill_done) begin
         r_data[w_idx] <= mem_rdata;
         r_tag[w_idx]  <= w_tag;
      end else if (!rst && w_store_hit) begin
         r_data[w_idx] <= w_merged;
      end
   end

endmodule

// File: tb/tb_dcache_unit.sv
// Directed bench for dcache_unit: table of single-cycle hit/non-memory
// vectors plus hand-written miss, write-back and reset-abort sequences.
module tb_dcache_unit;

   localparam int L = 4;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] LB  = 6'b100000;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] SB  = 6'b101000;
   localparam logic [5:0] NOP = 6'b111111;
   localparam logic [5:0] RTY = 6'b000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] rt_data;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] cache_rdata;
   logic [1:0]  byte_number;
   logic        is_word;
   logic        cache_hit;
   logic        cache_dirty;
   logic        reg_write;
   logic        pc_enable;
   logic        lock;

   int total = 0;
   int bad   = 0;

   dcache_unit #(.INDEX_BITS(13), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .addr(addr),
      .rt_data(rt_data), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .cache_rdata(cache_rdata), .byte_number(byte_number),
      .is_word(is_word), .cache_hit(cache_hit),
      .cache_dirty(cache_dirty), .reg_write(reg_write),
      .pc_enable(pc_enable), .lock(lock)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] rt;
      logic        e_hit;
      logic        e_rw;
      logic        e_dirty;
      logic [31:0] e_rdata;
      logic [1:0]  e_bn;
      logic        e_word;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] rt, input logic [31:0] mr);
      opcode    = op;
      addr      = a;
      rt_data   = rt;
      mem_rdata = mr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int i);
      drive(vecs[i].op, vecs[i].a, vecs[i].rt, 32'h0);
      @(negedge clk);
      chk({vecs[i].name, ".lock"}, 32'(lock), 32'(0));
      chk({vecs[i].name, ".pc_en"}, 32'(pc_enable), 32'(1));
      chk({vecs[i].name, ".we"}, 32'(mem_we), 32'(0));
      chk({vecs[i].name, ".hit"}, 32'(cache_hit), 32'(vecs[i].e_hit));
      chk({vecs[i].name, ".rw"}, 32'(reg_write), 32'(vecs[i].e_rw));
      chk({vecs[i].name, ".dirty"}, 32'(cache_dirty), 32'(vecs[i].e_dirty));
      chk({vecs[i].name, ".rdata"}, cache_rdata, vecs[i].e_rdata);
      chk({vecs[i].name, ".bn"}, 32'(byte_number), 32'(vecs[i].e_bn));
      chk({vecs[i].name, ".word"}, 32'(is_word), 32'(vecs[i].e_word));
      next_cycle();
   endtask

   // Holds a missing op until the stall clears; returns lock/we cycle counts.
   task automatic run_miss(input string name, input logic [31:0] fill_addr,
                           input logic [31:0] wb_addr,
                           input logic [31:0] wb_data,
                           output int n_lock, output int n_we);
      bit addr_ok = 1'b1;
      bit data_ok = 1'b1;
      n_lock = 0;
      n_we   = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!lock) break;
         n_lock++;
         if (mem_we) begin
            n_we++;
            if (mem_addr !== wb_addr) addr_ok = 1'b0;
            if (mem_wdata !== wb_data) data_ok = 1'b0;
         end else if (mem_addr !== fill_addr) begin
            addr_ok = 1'b0;
         end
         if (reg_write) data_ok = 1'b0;
         next_cycle();
      end
      chk({name, ".addr_ok"}, 32'(addr_ok), 32'(1));
      chk({name, ".data_ok"}, 32'(data_ok), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl;
      int nw;

      vecs[0]  = '{"sw_hit",   SW,  32'h10,   32'h11223344, 1, 0, 0, 32'hDEADBEEF, 0, 1};
      vecs[1]  = '{"lw_after", LW,  32'h10,   32'h0,        1, 1, 1, 32'h11223344, 0, 1};
      vecs[2]  = '{"sb_b3",    SB,  32'h13,   32'h000000AB, 1, 0, 1, 32'h11223344, 3, 0};
      vecs[3]  = '{"lb_b3",    LB,  32'h13,   32'h0,        1, 1, 1, 32'hAB223344, 3, 0};
      vecs[4]  = '{"nop",      NOP, 32'h10,   32'hFFFFFFFF, 1, 0, 1, 32'hAB223344, 0, 0};
      vecs[5]  = '{"rtype",    RTY, 32'h10,   32'hFFFFFFFF, 1, 0, 1, 32'hAB223344, 0, 0};
      vecs[6]  = '{"lw_keep",  LW,  32'h10,   32'h0,        1, 1, 1, 32'hAB223344, 0, 1};
      vecs[7]  = '{"sb_b1",    SB,  32'h8011, 32'h00000055, 1, 0, 0, 32'hCAFEF00D, 1, 0};
      vecs[8]  = '{"lw_merge", LW,  32'h8010, 32'h0,        1, 1, 1, 32'hCAFE550D, 0, 1};
      vecs[9]  = '{"old_miss", NOP, 32'h10,   32'h0,        0, 0, 1, 32'hCAFE550D, 0, 0};
      vecs[10] = '{"sw_merge", NOP, 32'h4020, 32'h0,        1, 0, 1, 32'h12345678, 0, 0};

      rst = 1'b1;
      drive(NOP, 32'h10, 32'h0, 32'h0);
      repeat (3) next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst.lock", 32'(lock), 32'(0));
      chk("rst.pc_en", 32'(pc_enable), 32'(1));
      chk("rst.we", 32'(mem_we), 32'(0));
      chk("rst.hit", 32'(cache_hit), 32'(0));
      next_cycle();

      drive(LW, 32'h10, 32'h0, 32'hDEADBEEF);
      run_miss("clean", 32'h10, 32'h0, 32'h0, nl, nw);
      chk("clean.stall", 32'(nl), 32'(1 + L));
      chk("clean.we", 32'(nw), 32'(0));
      chk("clean.hit", 32'(cache_hit), 32'(1));
      chk("clean.rw", 32'(reg_write), 32'(1));
      chk("clean.rdata", cache_rdata, 32'hDEADBEEF);
      next_cycle();

      for (int i = 0; i < 7; i++) run_vec(i);

      drive(LW, 32'h8010, 32'h0, 32'hCAFEF00D);
      run_miss("dirty", 32'h8010, 32'h10, 32'hAB223344, nl, nw);
      chk("dirty.stall", 32'(nl), 32'(1 + 2 * L));
      chk("dirty.we", 32'(nw), 32'(L));
      chk("dirty.hit", 32'(cache_hit), 32'(1));
      chk("dirty.rw", 32'(reg_write), 32'(1));
      chk("dirty.dirty", 32'(cache_dirty), 32'(0));
      chk("dirty.rdata", cache_rdata, 32'hCAFEF00D);
      next_cycle();

      for (int i = 7; i < 10; i++) run_vec(i);

      drive(SW, 32'h4020, 32'h12345678, 32'h0);
      run_miss("swmiss", 32'h4020, 32'h0, 32'h0, nl, nw);
      chk("swmiss.stall", 32'(nl), 32'(1 + L));
      chk("swmiss.fill", cache_rdata, 32'h0);
      chk("swmiss.dirty", 32'(cache_dirty), 32'(0));
      next_cycle();
      run_vec(10);

      drive(LW, 32'h30, 32'h0, 32'h0);
      @(negedge clk);
      chk("rfill.miss_lock", 32'(lock), 32'(1));
      next_cycle();
      @(negedge clk);
      chk("rfill.fill_lock", 32'(lock), 32'(1));
      rst = 1'b1;
      drive(NOP, 32'h8010, 32'h0, 32'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rfill.lock", 32'(lock), 32'(0));
      chk("rfill.pc_en", 32'(pc_enable), 32'(1));
      chk("rfill.we", 32'(mem_we), 32'(0));
      chk("rfill.hit", 32'(cache_hit), 32'(0));
      next_cycle();
      drive(LW, 32'h8010, 32'h0, 32'h0);
      @(negedge clk);
      chk("rfill.relock", 32'(lock), 32'(1));
      chk("rfill.rw", 32'(reg_write), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
